// File: rtl/cmd_deserializer.sv
// SD host CMD-line receiver: samples one bit per clock into a BITS-wide frame
// and checks the start bit, end bit and CRC7 of the response.
module cmd_deserializer #(
    parameter int BITS         = 48,
    parameter int BITS_COUNTER = 8,
    parameter int TIMEOUT      = 64,
    parameter int TIMEOUT_W    = 7,
    parameter int CRC_CHECK    = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            cmd_in,
    output logic [BITS-1:0] data,
    output logic            busy,
    output logic            valid,
    output logic            crc_err,
    output logic            end_err,
    output logic            timeout
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        RECEIVE,
        CHECK
    } state_t;

    localparam logic [BITS_COUNTER-1:0] BMAX  = BITS_COUNTER'(BITS - 1);
    localparam logic [BITS_COUNTER-1:0] CLAST = BITS_COUNTER'(BITS - 9);
    localparam logic [TIMEOUT_W-1:0]    TMAX  = TIMEOUT_W'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic                    enable_q;
    logic [BITS-1:0]         data_q, data_d;
    logic [BITS_COUNTER-1:0] bcnt_q, bcnt_d;
    logic [TIMEOUT_W-1:0]    tcnt_q, tcnt_d;
    logic [6:0]              crc_q, crc_d;
    logic                    valid_q, valid_d;
    logic                    crc_err_q, crc_err_d;
    logic                    end_err_q, end_err_d;
    logic                    timeout_q, timeout_d;
    logic [6:0]              crc_rx;

    function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // CRC field on the wire is MSB-first, so data[BITS-8] is crc bit 6
    always_comb begin
        crc_rx = '0;
        for (int i = 0; i < 7; i++) begin
            crc_rx[6-i] = data_q[BITS-8+i];
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        bcnt_d    = bcnt_q;
        tcnt_d    = tcnt_q;
        crc_d     = crc_q;
        valid_d   = 1'b0;
        crc_err_d = 1'b0;
        end_err_d = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && !enable_q) begin
                    state_d = WAIT_START;
                    tcnt_d  = '0;
                end
            end
            WAIT_START: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (!cmd_in) begin
                    state_d   = RECEIVE;
                    data_d[0] = 1'b0;
                    bcnt_d    = BITS_COUNTER'(1);
                    crc_d     = crc7_next(7'd0, 1'b0);
                end else if (tcnt_q == TMAX) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            RECEIVE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    for (int i = 0; i < BITS; i++) begin
                        if (bcnt_q == BITS_COUNTER'(i)) data_d[i] = cmd_in;
                    end
                    if (bcnt_q <= CLAST) crc_d = crc7_next(crc_q, cmd_in);
                    if (bcnt_q == BMAX) begin
                        // end bit: CRC field is complete, flag results now
                        state_d   = CHECK;
                        valid_d   = 1'b1;
                        crc_err_d = (CRC_CHECK != 0) && (crc_q != crc_rx);
                        end_err_d = ~cmd_in;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            enable_q  <= 1'b0;
            data_q    <= '0;
            bcnt_q    <= '0;
            tcnt_q    <= '0;
            crc_q     <= '0;
            valid_q   <= 1'b0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            enable_q  <= enable;
            data_q    <= data_d;
            bcnt_q    <= bcnt_d;
            tcnt_q    <= tcnt_d;
            crc_q     <= crc_d;
            valid_q   <= valid_d;
            crc_err_q <= crc_err_d;
            end_err_q <= end_err_d;
            timeout_q <= timeout_d;
        end
    end

    assign data    = data_q;
    assign busy    = (state_q == WAIT_START) || (state_q == RECEIVE);
    assign valid   = valid_q;
    assign crc_err = crc_err_q;
    assign end_err = end_err_q;
    assign timeout = timeout_q;

endmodule
